alu_control_unit: RTL and testbench

ALU_CONTROL_UNIT -- requirements
Module: alu_control_unit

---
 rtl/alu_control_unit.sv | 188 ++++++++++++++++++
 tb/tb_alu_control_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_unit.sv
// Multi-cycle control unit: latches one instruction, decodes it and sequences
// IDLE -> EXEC -> (MULT) -> WB, issuing register-write / branch / illegal strobes in WB.
module alu_control_unit #(
    parameter int unsigned MULT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        zero,
    output logic [2:0]  aluop,
    output logic [2:0]  readreg1,
    output logic [2:0]  readreg2,
    output logic [2:0]  writereg,
    output logic [7:0]  immediate,
    output logic        imm_sel,
    output logic        neg_sel,
    output logic        writeenable,
    output logic        branch_taken,
    output logic [7:0]  offset,
    output logic        illegal
);

    if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : gen_bad_param
        $error("MULT_CYCLES must be in 1..15");
    end

    localparam logic [3:0] MultLoad = 4'(MULT_CYCLES - 1);

    localparam logic [2:0] AluFwd   = 3'b000;
    localparam logic [2:0] AluAdd   = 3'b001;
    localparam logic [2:0] AluAnd   = 3'b010;
    localparam logic [2:0] AluOr    = 3'b011;
    localparam logic [2:0] AluMult  = 3'b100;
    localparam logic [2:0] AluShift = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StMult,
        StWb
    } state_e;

    state_e      state_q;
    logic [31:0] ir_q;
    logic        loaded_q;
    logic [3:0]  cnt_q;
    logic        zero_q;

    logic [7:0] opcode;
    logic [2:0] dec_aluop;
    logic [7:0] dec_imm;
    logic       dec_imm_sel;
    logic       dec_neg_sel;
    logic       dec_writes;
    logic       dec_jump;
    logic       dec_beq;
    logic       dec_mult;
    logic       dec_illegal;
    logic       in_wb;
    logic       unused_ir;

    assign opcode    = ir_q[31:24];
    assign unused_ir = ^ir_q[15:11];

    // loaded_q keeps every decoded control at zero until the first instruction arrives,
    // since an all-zero IR would otherwise decode as loadi.
    always_comb begin
        dec_aluop   = AluFwd;
        dec_imm     = ir_q[7:0];
        dec_imm_sel = 1'b0;
        dec_neg_sel = 1'b0;
        dec_writes  = 1'b0;
        dec_jump    = 1'b0;
        dec_beq     = 1'b0;
        dec_mult    = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            8'h00: begin
                dec_imm_sel = 1'b1;
                dec_writes  = 1'b1;
            end
            8'h01: dec_writes = 1'b1;
            8'h02: begin
                dec_aluop  = AluAdd;
                dec_writes = 1'b1;
            end
            8'h03: begin
                dec_aluop   = AluAdd;
                dec_neg_sel = 1'b1;
                dec_writes  = 1'b1;
            end
            8'h04: begin
                dec_aluop  = AluAnd;
                dec_writes = 1'b1;
            end
            8'h05: begin
                dec_aluop  = AluOr;
                dec_writes = 1'b1;
            end
            8'h06: dec_jump = 1'b1;
            8'h07: begin
                dec_aluop   = AluAdd;
                dec_neg_sel = 1'b1;
                dec_beq     = 1'b1;
            end
            8'h08: begin
                dec_aluop  = AluMult;
                dec_mult   = 1'b1;
                dec_writes = 1'b1;
            end
            8'h09, 8'h0A: begin
                dec_aluop   = AluShift;
                dec_imm_sel = 1'b1;
                dec_writes  = 1'b1;
                dec_imm     = {(opcode == 8'h0A), 4'b0000, ir_q[2:0]};
            end
            default: dec_illegal = 1'b1;
        endcase
        if (!loaded_q) begin
            dec_aluop   = AluFwd;
            dec_imm     = 8'h00;
            dec_imm_sel = 1'b0;
            dec_neg_sel = 1'b0;
            dec_writes  = 1'b0;
            dec_jump    = 1'b0;
            dec_beq     = 1'b0;
            dec_mult    = 1'b0;
            dec_illegal = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            ir_q     <= 32'h0;
            loaded_q <= 1'b0;
            cnt_q    <= 4'h0;
            zero_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        ir_q     <= instruction;
                        loaded_q <= 1'b1;
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    // beq resolves on the ZERO seen at this edge, not the live flag in WB
                    zero_q <= zero;
                    if (dec_mult) begin
                        cnt_q   <= MultLoad;
                        state_q <= StMult;
                    end else begin
                        state_q <= StWb;
                    end
                end
                StMult: begin
                    if (cnt_q == 4'h0) begin
                        state_q <= StWb;
                    end else begin
                        cnt_q <= cnt_q - 4'h1;
                    end
                end
                StWb: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_wb        = (state_q == StWb);
    assign instr_ready  = (state_q == StIdle);
    assign writeenable  = in_wb & dec_writes;
    assign branch_taken = in_wb & (dec_jump | (dec_beq & zero_q));
    assign illegal      = in_wb & dec_illegal;

    assign aluop     = dec_aluop;
    assign immediate = dec_imm;
    assign imm_sel   = dec_imm_sel;
    assign neg_sel   = dec_neg_sel;
    assign readreg1  = ir_q[10:8];
    assign readreg2  = ir_q[2:0];
    assign writereg  = ir_q[18:16];
    assign offset    = ir_q[23:16];

endmodule

// File: tb/tb_alu_control_unit.sv
// Randomized self-checking bench for alu_control_unit against a table-driven
// behavioural model of decode and instruction timing.
module tb_alu_control_unit;

    localparam int unsigned MC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        zero;
    logic [2:0]  aluop, readreg1, readreg2, writereg;
    logic [7:0]  immediate, offset;
    logic        imm_sel, neg_sel, writeenable, branch_taken, illegal;

    alu_control_unit #(.MULT_CYCLES(MC)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .zero(zero), .aluop(aluop), .readreg1(readreg1),
        .readreg2(readreg2), .writereg(writereg), .immediate(immediate), .imm_sel(imm_sel),
        .neg_sel(neg_sel), .writeenable(writeenable), .branch_taken(branch_taken),
        .offset(offset), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] aluop;
        logic [7:0] imm;
        logic       imm_sel, neg_sel, we, jump, beq, ill;
        int         wb_k;
    } exp_t;

    // ALU select per defined opcode 0x00..0x0A
    int alu_tbl [11] = '{0, 0, 1, 1, 2, 3, 0, 1, 4, 5, 5};

    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        int op = int'(ins[31:24]);
        e.aluop = 3'd0; e.imm = ins[7:0];
        e.imm_sel = 0; e.neg_sel = 0; e.we = 0; e.jump = 0; e.beq = 0; e.ill = 0;
        e.wb_k = 2;
        if (op > 10) begin
            e.ill = 1;
        end else begin
            e.aluop   = 3'(alu_tbl[op]);
            e.we      = (op != 6) && (op != 7);
            e.jump    = (op == 6);
            e.beq     = (op == 7);
            e.imm_sel = (op == 0) || (op == 9) || (op == 10);
            e.neg_sel = (op == 3) || (op == 7);
            if (op == 9 || op == 10) e.imm = 8'((op == 10) * 128 + int'(ins[2:0]));
            if (op == 8) e.wb_k = 2 + MC;
        end
        return e;
    endfunction

    // Observations filled in by watch()
    int         we_n, we_k, br_n, ill_n, ready_k, alu_drift;
    logic [2:0] x_alu, x_rr1, x_rr2, x_wr, idle_alu, wr_at_we;
    logic [7:0] x_imm, x_off;
    logic       x_isel, x_nsel;

    // Issue one instruction from IDLE and record what the DUT does until it is ready again.
    // The ZERO input is inverted after EXEC so a live-ZERO branch would be visible.
    task automatic watch(input logic [31:0] ins, input logic z, input bit noise);
        @(negedge clk);
        instruction = ins; instr_valid = 1'b1; zero = z;
        we_n = 0; we_k = 0; br_n = 0; ill_n = 0; ready_k = 99; alu_drift = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            zero = (k >= 2) ? ~z : z;
            #1;
            if (writeenable) begin we_n++; we_k = k; wr_at_we = writereg; end
            if (branch_taken) br_n++;
            if (illegal) ill_n++;
            if (k == 1) begin
                x_alu = aluop; x_rr1 = readreg1; x_rr2 = readreg2; x_wr = writereg;
                x_imm = immediate; x_off = offset; x_isel = imm_sel; x_nsel = neg_sel;
            end else if (aluop !== x_alu) begin
                alu_drift++;
            end
            if (instr_ready) begin
                ready_k = k; idle_alu = aluop;
                break;
            end
            if (noise) begin instruction = $urandom; instr_valid = 1'b1; end
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; instr_valid = 1'b0; instruction = 32'h0; zero = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (instr_ready !== 1'b1 || writeenable !== 1'b0 || branch_taken !== 1'b0 ||
            illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobes: ready=%b we=%b br=%b ill=%b want 1 0 0 0",
                     instr_ready, writeenable, branch_taken, illegal);
        end
        total++;
        if ({aluop, imm_sel, neg_sel, immediate, offset, readreg1, readreg2, writereg} !== '0) begin
            bad++;
            $display("FAIL reset_decode: alu=%h isel=%b nsel=%b imm=%h off=%h rr=%0d/%0d wr=%0d want 0",
                     aluop, imm_sel, neg_sel, immediate, offset, readreg1, readreg2, writereg);
        end
    endtask

    task automatic test_add;
        watch(32'h02_03_01_02, 1'b0, 1'b0);
        total++;
        if (x_alu !== 3'b001 || x_rr1 !== 3'd1 || x_rr2 !== 3'd2 || x_wr !== 3'd3) begin
            bad++;
            $display("FAIL add_decode: alu=%b rr1=%0d rr2=%0d wr=%0d want 001 1 2 3",
                     x_alu, x_rr1, x_rr2, x_wr);
        end
        total++;
        if (we_n !== 1 || we_k !== 2) begin
            bad++;
            $display("FAIL add_we: count=%0d at=%0d want 1 at 2", we_n, we_k);
        end
    endtask

    task automatic test_imm_shift;
        watch(32'h00_05_00_7F, 1'b0, 1'b0);
        total++;
        if (x_isel !== 1'b1 || x_imm !== 8'h7F || x_wr !== 3'd5 || we_n !== 1) begin
            bad++;
            $display("FAIL loadi: isel=%b imm=%h wr=%0d we_n=%0d want 1 7f 5 1",
                     x_isel, x_imm, x_wr, we_n);
        end
        watch(32'h0A_01_02_03, 1'b0, 1'b0);
        total++;
        if (x_imm !== 8'h83 || x_alu !== 3'b101 || x_isel !== 1'b1) begin
            bad++;
            $display("FAIL srl: imm=%h alu=%b isel=%b want 83 101 1", x_imm, x_alu, x_isel);
        end
        watch(32'h09_01_02_F5, 1'b0, 1'b0);
        total++;
        if (x_imm !== 8'h05 || x_alu !== 3'b101) begin
            bad++;
            $display("FAIL sll: imm=%h alu=%b want 05 101", x_imm, x_alu);
        end
    endtask

    task automatic test_beq;
        watch(32'h07_FC_01_02, 1'b1, 1'b0);
        total++;
        if (br_n !== 1 || x_off !== 8'hFC || we_n !== 0 || x_nsel !== 1'b1) begin
            bad++;
            $display("FAIL beq_taken: br=%0d off=%h we=%0d nsel=%b want 1 fc 0 1",
                     br_n, x_off, we_n, x_nsel);
        end
        watch(32'h07_FC_01_02, 1'b0, 1'b0);
        total++;
        if (br_n !== 0 || we_n !== 0) begin
            bad++;
            $display("FAIL beq_not_taken: br=%0d we=%0d want 0 0", br_n, we_n);
        end
    endtask

    task automatic test_mult_busy;
        watch(32'h08_06_01_02, 1'b0, 1'b1);
        total++;
        if (ready_k !== MC + 3) begin
            bad++;
            $display("FAIL mult_busy: ready after %0d want %0d", ready_k, MC + 3);
        end
        total++;
        if (we_n !== 1 || we_k !== MC + 2 || wr_at_we !== 3'd6) begin
            bad++;
            $display("FAIL mult_we: count=%0d at=%0d wr=%0d want 1 at %0d wr 6",
                     we_n, we_k, wr_at_we, MC + 2);
        end
        total++;
        if (x_alu !== 3'b100 || alu_drift !== 0 || idle_alu !== 3'b100) begin
            bad++;
            $display("FAIL mult_aluop: alu=%b drift=%0d idle=%b want 100 0 100",
                     x_alu, alu_drift, idle_alu);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        instruction = 32'h08_02_01_03; instr_valid = 1'b1;
        @(negedge clk); instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (instr_ready !== 1'b1 || aluop !== 3'b000 || writeenable !== 1'b0) begin
            bad++;
            $display("FAIL reset_mult: ready=%b alu=%b we=%b want 1 000 0",
                     instr_ready, aluop, writeenable);
        end
        seen = 0;
        repeat (MC + 6) begin
            @(negedge clk); #1;
            if (writeenable || branch_taken) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_mult_drop: strobes=%0d want 0", seen);
        end
        // reset and a valid instruction in the same cycle
        @(negedge clk);
        reset = 1'b1; instruction = 32'h02_03_01_02; instr_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; instr_valid = 1'b0;
        #1;
        seen = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (!instr_ready || writeenable) seen++;
        end
        total++;
        if (seen !== 0 || aluop !== 3'b000) begin
            bad++;
            $display("FAIL reset_priority: busy_or_we=%0d alu=%b want 0 000", seen, aluop);
        end
    endtask

    task automatic test_illegal;
        watch(32'hFF_01_02_03, 1'b1, 1'b0);
        total++;
        if (ill_n !== 1 || we_n !== 0 || br_n !== 0 || x_alu !== 3'b000) begin
            bad++;
            $display("FAIL illegal_ff: ill=%0d we=%0d br=%0d alu=%b want 1 0 0 000",
                     ill_n, we_n, br_n, x_alu);
        end
    endtask

    task automatic test_random;
        exp_t        e;
        logic [31:0] ins;
        logic        z;
        int          op;
        for (int n = 0; n < 40; n++) begin
            op  = (n % 8 == 7) ? int'($urandom_range(11, 255)) : int'($urandom_range(0, 10));
            ins = {8'(op), 24'($urandom)};
            z   = 1'($urandom);
            e   = model(ins);
            watch(ins, z, 1'($urandom));
            total++;
            if (ready_k !== e.wb_k + 1) begin
                bad++;
                $display("FAIL rand_latency: ins=%h ready_after=%0d want %0d",
                         ins, ready_k, e.wb_k + 1);
            end
            total++;
            if (we_n !== int'(e.we) || (e.we && we_k !== e.wb_k)) begin
                bad++;
                $display("FAIL rand_we: ins=%h count=%0d at=%0d want %0d at %0d",
                         ins, we_n, we_k, e.we, e.wb_k);
            end
            total++;
            if (br_n !== int'(e.jump | (e.beq & z)) || ill_n !== int'(e.ill)) begin
                bad++;
                $display("FAIL rand_br_ill: ins=%h z=%b br=%0d ill=%0d want %0d %0d",
                         ins, z, br_n, ill_n, e.jump | (e.beq & z), e.ill);
            end
            total++;
            if (x_imm !== e.imm || x_isel !== e.imm_sel || x_nsel !== e.neg_sel ||
                x_off !== ins[23:16] || x_rr1 !== ins[10:8] || x_rr2 !== ins[2:0] ||
                x_wr !== ins[18:16]) begin
                bad++;
                $display("FAIL rand_fields: ins=%h imm=%h isel=%b nsel=%b off=%h rr=%0d/%0d wr=%0d want %h %b %b",
                         ins, x_imm, x_isel, x_nsel, x_off, x_rr1, x_rr2, x_wr,
                         e.imm, e.imm_sel, e.neg_sel);
            end
            if (op != 6) begin
                total++;
                if (x_alu !== e.aluop || alu_drift !== 0 || idle_alu !== e.aluop) begin
                    bad++;
                    $display("FAIL rand_aluop: ins=%h alu=%b drift=%0d idle=%b want %b",
                             ins, x_alu, alu_drift, idle_alu, e.aluop);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm_shift();
        test_beq();
        test_mult_busy();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
